// File: rtl/riscv_pkg.sv
// Shared RV32I types: memory funct3 codes, arbiter FSM/owner enums and a
// helper that classifies a data-port request as misaligned or illegal.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int STARVE_LIMIT_DEFAULT = 4;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_mem_t;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_t;
  typedef enum logic {OWN_IF, OWN_DM} arb_owner_t;

  // Unsigned loads have no store counterpart, so 100/101 are illegal on a store.
  function automatic logic dm_req_err(input logic we, input logic [2:0] f3,
                                      input logic [1:0] lo);
    case (f3)
      F3_B:    return 1'b0;
      F3_H:    return lo[0];
      F3_W:    return lo != 2'b00;
      F3_BU:   return we;
      F3_HU:   return we | lo[0];
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half from a read word and sign- or
// zero-extends it according to the load funct3.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] sh;
  assign sh = word_i >> {addr_i, 3'b000};

  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_B:    data_o = {{24{sh[7]}}, sh[7:0]};
      F3_BU:   data_o = {24'b0, sh[7:0]};
      F3_H:    data_o = {{16{sh[15]}}, sh[15:0]};
      F3_HU:   data_o = {16'b0, sh[15:0]};
      F3_W:    data_o = word_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access: DM-first
// arbitration with an IF anti-starvation counter, issue/wait/respond sequencing.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_rsp_valid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_err,
  input  logic                  dm_req_valid,
  output logic                  dm_req_ready,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  input  logic [2:0]            dm_funct3,
  output logic                  dm_rsp_valid,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_err,
  output logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    arb_owner_t            owner;
    logic                  we;
    logic [2:0]            f3;
    logic [1:0]            lo;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [3:0]            wstrb;
    logic                  err;
  } req_t;

  arb_state_t            state_q, state_d;
  req_t                  req_q, req_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  if_first, grant_if, grant_dm, idle;
  logic [DATA_WIDTH-1:0] load_data;

  load_align u_load_align (
    .word_i   (mem_rdata),
    .addr_i   (req_q.lo),
    .funct3_i (req_q.f3),
    .data_o   (load_data)
  );

  // IF only overtakes a pending DM request once the starvation count saturates.
  assign idle     = (state_q == ARB_IDLE) && !rst;
  assign if_first = if_req_valid && (!dm_req_valid || starve_q == SW'(STARVE_LIMIT));
  assign grant_if = idle && if_first;
  assign grant_dm = idle && dm_req_valid && !if_first;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    starve_d   = starve_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_if) begin
          req_d       = '0;
          req_d.owner = OWN_IF;
          req_d.f3    = F3_W;
          req_d.addr  = {if_addr[ADDR_WIDTH-1:2], 2'b00};
          req_d.err   = if_addr[1:0] != 2'b00;
          starve_d    = '0;
          if (req_d.err) if_rdata_d = '0;
          state_d     = req_d.err ? ARB_RESP : ARB_ISSUE;
        end else if (grant_dm) begin
          req_d       = '0;
          req_d.owner = OWN_DM;
          req_d.we    = dm_we;
          req_d.f3    = dm_funct3;
          req_d.lo    = dm_addr[1:0];
          req_d.addr  = {dm_addr[ADDR_WIDTH-1:2], 2'b00};
          req_d.err   = dm_req_err(dm_we, dm_funct3, dm_addr[1:0]);
          if (dm_we && !req_d.err) begin
            case (dm_funct3)
              F3_B: begin
                req_d.wdata = {4{dm_wdata[7:0]}};
                req_d.wstrb = 4'b0001 << dm_addr[1:0];
              end
              F3_H: begin
                req_d.wdata = {2{dm_wdata[15:0]}};
                req_d.wstrb = dm_addr[1] ? 4'b1100 : 4'b0011;
              end
              default: begin
                req_d.wdata = dm_wdata;
                req_d.wstrb = 4'b1111;
              end
            endcase
          end
          if (!if_req_valid)                        starve_d = '0;
          else if (starve_q != SW'(STARVE_LIMIT))   starve_d = starve_q + SW'(1);
          if (req_d.err) dm_rdata_d = '0;
          state_d = req_d.err ? ARB_RESP : ARB_ISSUE;
        end
      end
      ARB_ISSUE: if (mem_ready) state_d = ARB_WAIT;
      ARB_WAIT: begin
        if (mem_rvalid) begin
          if (req_q.owner == OWN_IF) if_rdata_d = mem_rdata;
          else                       dm_rdata_d = req_q.we ? '0 : load_data;
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      req_q      <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      starve_q   <= starve_d;
    end
  end

  assign if_req_ready = grant_if;
  assign dm_req_ready = grant_dm;

  assign mem_req   = state_q == ARB_ISSUE;
  assign mem_we    = mem_req & req_q.we;
  assign mem_addr  = mem_req ? req_q.addr  : '0;
  assign mem_wdata = mem_req ? req_q.wdata : '0;
  assign mem_wstrb = mem_req ? req_q.wstrb : 4'b0000;

  assign if_rsp_valid = (state_q == ARB_RESP) && (req_q.owner == OWN_IF);
  assign dm_rsp_valid = (state_q == ARB_RESP) && (req_q.owner == OWN_DM);
  assign if_err       = if_rsp_valid & req_q.err;
  assign dm_err       = dm_rsp_valid & req_q.err;
  assign if_rdata     = if_rdata_q;
  assign dm_rdata     = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: a byte-level reference memory predicts every response and
// memory-bus beat; a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic        if_req_valid, if_req_ready, if_rsp_valid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req_valid, dm_req_ready, dm_we, dm_rsp_valid, dm_err;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [2:0]  dm_funct3;
  logic        mem_req, mem_ready, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata), .if_err(if_err),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_funct3(dm_funct3),
    .dm_rsp_valid(dm_rsp_valid), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_req(mem_req), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { logic [31:0] rdata; logic err; int unsigned acc; } rsp_t;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] strb; logic [31:0] data; } mtx_t;

  rsp_t if_q[$], dm_q[$];
  mtx_t mq[$];
  logic [31:0] phys[256];
  logic [31:0] refm[256];
  bit          if_acc, dm_acc, zero_wait, manual, pend, log_on;
  logic [31:0] pend_data, if_hold, dm_hold;
  int          streak;
  bit          glog[$];

  // monitor scratch
  rsp_t        m_e;
  mtx_t        m_t;
  int          m_sz, m_lane;
  bit          m_ill, m_mis, m_expdm;
  logic [31:0] m_w, m_mask;
  logic [7:0]  m_idx;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        streak = 0;
      end else begin
        if (if_req_ready || dm_req_ready) begin
          m_expdm = dm_req_valid && !(if_req_valid && streak == LIMIT);
          chk("ready_excl", {31'b0, if_req_ready & dm_req_ready}, 32'd0);
          chk("grant_dm", {31'b0, dm_req_ready}, {31'b0, m_expdm});
          if (log_on) glog.push_back(dm_req_ready);
          if (m_expdm) streak = if_req_valid ? ((streak < LIMIT) ? streak + 1 : LIMIT) : 0;
          else         streak = 0;
        end
        if (if_req_valid && if_req_ready) begin
          if_acc  = 1'b1;
          m_idx   = if_addr[9:2];
          m_e.err = if_addr[1:0] != 2'b00;
          m_e.rdata = m_e.err ? 32'h0 : refm[m_idx];
          m_e.acc = cyc;
          if_q.push_back(m_e);
          if (!m_e.err) begin
            m_t.we = 1'b0; m_t.addr = {if_addr[31:2], 2'b00}; m_t.strb = 4'h0; m_t.data = 32'h0;
            mq.push_back(m_t);
          end
        end
        if (dm_req_valid && dm_req_ready) begin
          dm_acc = 1'b1;
          m_idx  = dm_addr[9:2];
          case (dm_funct3)
            3'b000, 3'b100: m_sz = 1;
            3'b001, 3'b101: m_sz = 2;
            3'b010:         m_sz = 4;
            default:        m_sz = 0;
          endcase
          m_ill = (m_sz == 0) || (dm_we && dm_funct3[2]);
          m_mis = 1'b0;
          if (!m_ill) m_mis = (int'(dm_addr[1:0]) % m_sz) != 0;
          m_e.err = m_ill | m_mis;
          m_e.rdata = 32'h0;
          m_e.acc = cyc;
          if (!m_e.err) begin
            m_t.we = dm_we; m_t.addr = {dm_addr[31:2], 2'b00}; m_t.strb = 4'h0; m_t.data = 32'h0;
            if (dm_we) begin
              for (int k = 0; k < m_sz; k++) begin
                m_lane = int'(dm_addr[1:0]) + k;
                m_t.strb[m_lane] = 1'b1;
                m_t.data[8*m_lane +: 8] = dm_wdata[8*k +: 8];
                refm[m_idx][8*m_lane +: 8] = dm_wdata[8*k +: 8];
              end
            end else begin
              m_w    = refm[m_idx] >> (8 * int'(dm_addr[1:0]));
              m_mask = (m_sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * m_sz)) - 32'h1);
              m_w    = m_w & m_mask;
              if (!dm_funct3[2] && m_sz < 4 && m_w[8*m_sz-1]) m_w = m_w | ~m_mask;
              m_e.rdata = m_w;
            end
            mq.push_back(m_t);
          end
          dm_q.push_back(m_e);
        end
        if (mem_req && mem_ready) begin
          if (mq.size() == 0) chk("mem_unexpected", {31'b0, mem_req}, 32'd0);
          else begin
            m_t = mq.pop_front();
            chk("mem_addr", mem_addr, m_t.addr);
            chk("mem_we", {31'b0, mem_we}, {31'b0, m_t.we});
            chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, m_t.strb});
            m_idx = mem_addr[9:2];
            for (int l = 0; l < 4; l++)
              if (m_t.strb[l]) begin
                chk("mem_wdata_lane", {24'b0, mem_wdata[8*l +: 8]}, {24'b0, m_t.data[8*l +: 8]});
                phys[m_idx][8*l +: 8] = mem_wdata[8*l +: 8];
              end
            pend_data = phys[m_idx];
            pend = 1'b1;
          end
        end
        if (if_rsp_valid) begin
          if (if_q.size() == 0) chk("if_rsp_unexpected", {31'b0, if_rsp_valid}, 32'd0);
          else begin
            m_e = if_q.pop_front();
            chk("if_rdata", if_rdata, m_e.rdata);
            chk("if_err", {31'b0, if_err}, {31'b0, m_e.err});
            if (zero_wait) chk("if_latency", cyc - m_e.acc, m_e.err ? 32'd1 : 32'd3);
            if_hold = m_e.rdata;
          end
        end else chk("if_rdata_hold", if_rdata, if_hold);
        if (dm_rsp_valid) begin
          if (dm_q.size() == 0) chk("dm_rsp_unexpected", {31'b0, dm_rsp_valid}, 32'd0);
          else begin
            m_e = dm_q.pop_front();
            chk("dm_rdata", dm_rdata, m_e.rdata);
            chk("dm_err", {31'b0, dm_err}, {31'b0, m_e.err});
            if (zero_wait) chk("dm_latency", cyc - m_e.acc, m_e.err ? 32'd1 : 32'd3);
            dm_hold = m_e.rdata;
          end
        end else chk("dm_rdata_hold", dm_rdata, dm_hold);
      end
    end
  end

  // Memory side: random or zero-wait ready, read data returned from phys[]
  initial begin : responder
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (!manual) begin
        mem_ready = zero_wait ? 1'b1 : ($urandom_range(0, 1) == 1);
        if (pend && (zero_wait || $urandom_range(0, 2) == 0)) begin
          mem_rvalid = 1'b1; mem_rdata = pend_data; pend = 1'b0;
        end else begin
          mem_rvalid = 1'b0; mem_rdata = $urandom;
        end
      end
    end
  end

  task automatic drive_if(input logic [31:0] a);
    int t;
    @(posedge clk); #1;
    if_addr = a; if_req_valid = 1'b1; if_acc = 1'b0;
    t = 0;
    while (!if_acc && t < 500) begin @(negedge clk); #2; t++; end
    if (!if_acc) chk("if_accept_timeout", 32'(t), 32'd0);
    @(posedge clk); #1;
    if_req_valid = 1'b0;
  endtask

  task automatic drive_dm(input logic we, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] wd);
    int t;
    @(posedge clk); #1;
    dm_we = we; dm_addr = a; dm_funct3 = f3; dm_wdata = wd; dm_req_valid = 1'b1; dm_acc = 1'b0;
    t = 0;
    while (!dm_acc && t < 500) begin @(negedge clk); #2; t++; end
    if (!dm_acc) chk("dm_accept_timeout", 32'(t), 32'd0);
    @(posedge clk); #1;
    dm_req_valid = 1'b0;
  endtask

  task automatic wait_quiet();
    int t;
    t = 0;
    while ((if_q.size() + dm_q.size() + mq.size()) != 0 && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) chk("quiet_timeout", 32'(t), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  logic [2:0] legal_f3[5];
  bit         exp_pat[10];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    if_req_valid = 0; if_addr = 0; dm_req_valid = 0; dm_we = 0; dm_addr = 0;
    dm_wdata = 0; dm_funct3 = 0;
    zero_wait = 1; manual = 0; pend = 0; log_on = 0; streak = 0;
    if_hold = 0; dm_hold = 0; if_acc = 0; dm_acc = 0;
    legal_f3[0] = 3'b000; legal_f3[1] = 3'b001; legal_f3[2] = 3'b010;
    legal_f3[3] = 3'b100; legal_f3[4] = 3'b101;
    exp_pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    for (int i = 0; i < 256; i++) begin phys[i] = i * 32'h9E37_79B1; refm[i] = phys[i]; end

    // reset: valids held high, every output must stay low
    rst = 1'b1;
    @(posedge clk); #1;
    if_req_valid = 1'b1; dm_req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_if_ready", {31'b0, if_req_ready}, 32'd0);
    chk("rst_dm_ready", {31'b0, dm_req_ready}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    chk("rst_rsp", {30'b0, if_rsp_valid, dm_rsp_valid}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; if_req_valid = 1'b0; dm_req_valid = 1'b0;

    // directed cases
    phys[8'h40] = 32'h0050_0093; refm[8'h40] = 32'h0050_0093;
    drive_if(32'h100); wait_quiet();
    drive_dm(1'b1, 32'h203, 3'b000, 32'h0000_00AB); wait_quiet();
    chk("sb_byte3", {24'b0, phys[8'h80][31:24]}, 32'h0000_00AB);
    phys[8'h80] = 32'h80FF_1234; refm[8'h80] = 32'h80FF_1234;
    drive_dm(1'b0, 32'h202, 3'b000, 32'h0);
    drive_dm(1'b0, 32'h202, 3'b100, 32'h0);
    drive_dm(1'b0, 32'h202, 3'b001, 32'h0);
    wait_quiet();
    chk("lh_last", dm_rdata, 32'hFFFF_80FF);
    drive_dm(1'b0, 32'h201, 3'b010, 32'h0);
    drive_dm(1'b1, 32'h203, 3'b001, 32'h1234);
    drive_dm(1'b0, 32'h200, 3'b011, 32'h0);
    drive_dm(1'b1, 32'h200, 3'b100, 32'h55);
    drive_if(32'h102);
    wait_quiet();

    // contention: both ports continuously requesting
    glog.delete(); log_on = 1'b1;
    fork
      begin repeat (3) drive_if(32'($urandom_range(0, 255)) << 2); end
      begin repeat (10) drive_dm(1'b0, 32'($urandom_range(0, 255)) << 2, 3'b010, 32'h0); end
    join
    log_on = 1'b0;
    wait_quiet();
    for (int i = 0; i < 10; i++)
      chk("contention_order", (i < glog.size()) ? {31'b0, glog[i]} : 32'hFFFF_FFFF,
          {31'b0, exp_pat[i]});

    // randomized traffic with a stalling memory
    zero_wait = 1'b0;
    fork
      begin
        repeat (40) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          drive_if(($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 1023))
                                               : (32'($urandom_range(0, 255)) << 2));
        end
      end
      begin
        repeat (60) begin
          logic [2:0] f3;
          repeat ($urandom_range(0, 3)) @(posedge clk);
          f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7))
                                           : legal_f3[$urandom_range(0, 4)];
          drive_dm(1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)), f3, $urandom);
        end
      end
    join
    wait_quiet();

    // reset while waiting for read data, then a late mem_rvalid
    zero_wait = 1'b1; manual = 1'b1;
    mem_ready = 1'b1; mem_rvalid = 1'b0;
    drive_if(32'h100);
    @(posedge clk); #1;
    rst = 1'b1;
    if_q.delete(); dm_q.delete(); mq.delete(); pend = 1'b0; if_hold = 0; dm_hold = 0;
    @(posedge clk); #1;
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("abort_mem_req_drop", {31'b0, mem_req}, 32'd0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_rsp", {30'b0, if_rsp_valid, dm_rsp_valid}, 32'd0);
    end
    manual = 1'b0;
    drive_if(32'h100);
    wait_quiet();

    chk("queues_empty", 32'(if_q.size() + dm_q.size() + mq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
